// File: rtl/dpm_shf_seq_if.sv
// dpm_shf_seq_if: WBUS load / start handshake and SRM control bundle for the
// DPM field-extract sequencer. The master side drives loads and start; the
// slave side (the sequencer) drives status and the active-low SRM controls.
interface dpm_shf_seq_if;
  logic [7:0] wbus_h;
  logic       ld_pos_h;
  logic       ld_size_h;
  logic       start_h;
  logic       busy_h;
  logic       done_h;
  logic       rsv_h;
  logic       pass_h;
  logic [4:0] shf_l;
  logic [1:0] pri_l;
  logic [5:0] sec_l;

  modport master (
    output wbus_h, ld_pos_h, ld_size_h, start_h,
    input  busy_h, done_h, rsv_h, pass_h, shf_l, pri_l, sec_l
  );

  modport slave (
    input  wbus_h, ld_pos_h, ld_size_h, start_h,
    output busy_h, done_h, rsv_h, pass_h, shf_l, pri_l, sec_l
  );
endinterface

// File: rtl/dpm_shf_seq.sv
// dpm_shf_seq: field-extract sequencer upstream of the DPM SRM slices.
// Holds POS/SIZE, and on start issues one or two single-cycle extract passes
// (two when the field straddles the longword boundary).
// Optional feature macro: SHF_SEQ_ZERO_SIZE_EN (SIZE=0 emits a literal-zero pass).
// The SRM function codes normally come from srkmacros.vh; fallbacks are kept
// here so the block builds stand-alone.
`ifndef PRI_EXTZ_MM
`define PRI_EXTZ_MM 2'b00
`endif
`ifndef PRI_EXTZ_MR
`define PRI_EXTZ_MR 2'b01
`endif
`ifndef PRI_EXTZ_RR
`define PRI_EXTZ_RR 2'b10
`endif
`ifndef PRI_SECOND
`define PRI_SECOND 2'b11
`endif
`ifndef SEC_LITZERO
`define SEC_LITZERO 6'h20
`endif

module dpm_shf_seq #(
  parameter int POS_W  = 5,
  parameter int SIZE_W = 6
) (
  input  logic          phase_h,
  input  logic          reset_l,
  dpm_shf_seq_if.slave  sif
);

  typedef enum logic [1:0] {ST_IDLE, ST_P1, ST_P2, ST_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [POS_W-1:0]    r_pos;
  logic [SIZE_W-1:0]   r_size;
  logic                r_split;
  logic [5:0]          r_p2_cnt;
  logic                r_busy, r_done, r_rsv, r_pass;
  logic [4:0]          r_shf;
  logic [1:0]          r_pri;
  logic [5:0]          r_sec;

  logic                w_split_nxt;
  logic [5:0]          w_p2_cnt_nxt;
  logic                w_busy, w_done, w_rsv, w_pass;
  logic [4:0]          w_shf;
  logic [1:0]          w_pri;
  logic [5:0]          w_sec;
  logic [SIZE_W:0]     w_end;
  logic                w_unused_wbus;

  // End bit of the field, one bit wider than SIZE so it never wraps.
  assign w_end = {{(SIZE_W + 1 - POS_W){1'b0}}, r_pos} + {1'b0, r_size};

  assign w_unused_wbus = ^sif.wbus_h[7:6];

  // Next state and the control values for the state being entered.
  always_comb begin
    w_state_nxt  = r_state;
    w_split_nxt  = r_split;
    w_p2_cnt_nxt = r_p2_cnt;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_rsv        = 1'b0;
    w_pass       = 1'b0;
    w_shf        = 5'h1F;
    w_pri        = ~`PRI_EXTZ_MM;
    w_sec        = 6'h3F;
    case (r_state)
      ST_IDLE: begin
        if (sif.start_h) begin
          if (r_size > 6'd32) begin
            // Reserved operand: report and finish without issuing a pass.
            w_state_nxt = ST_DONE;
            w_rsv       = 1'b1;
            w_done      = 1'b1;
          end else begin
            // Split decision and second-pass count are latched here so a
            // load in the same cycle cannot disturb the running sequence.
            w_state_nxt  = ST_P1;
            w_busy       = 1'b1;
            w_split_nxt  = (w_end > 7'd32);
            w_p2_cnt_nxt = w_end[5:0] - 6'd32;
            w_shf        = ~r_pos;
            w_sec        = ~r_size;
            if (w_end > 7'd32) begin
              w_pri = ~`PRI_EXTZ_MR;
            end else begin
              w_pri = ~`PRI_EXTZ_MM;
            end
`ifdef SHF_SEQ_ZERO_SIZE_EN
            if (r_size == 6'd0) begin
              w_shf = ~5'd0;
              w_pri = ~`PRI_SECOND;
              w_sec = ~`SEC_LITZERO;
            end else begin
              w_shf = ~r_pos;
            end
`endif
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_P1: begin
        if (r_split) begin
          w_state_nxt = ST_P2;
          w_busy      = 1'b1;
          w_pass      = 1'b1;
          w_shf       = ~5'd0;
          w_pri       = ~`PRI_EXTZ_RR;
          w_sec       = ~r_p2_cnt;
        end else begin
          w_state_nxt = ST_DONE;
          w_done      = 1'b1;
        end
      end
      ST_P2: begin
        w_state_nxt = ST_DONE;
        w_done      = 1'b1;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered SRM controls / status.
  always_ff @(posedge phase_h or negedge reset_l) begin
    if (!reset_l) begin
      r_state  <= ST_IDLE;
      r_split  <= 1'b0;
      r_p2_cnt <= 6'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rsv    <= 1'b0;
      r_pass   <= 1'b0;
      r_shf    <= 5'h1F;
      r_pri    <= ~`PRI_EXTZ_MM;
      r_sec    <= 6'h3F;
    end else begin
      r_state  <= w_state_nxt;
      r_split  <= w_split_nxt;
      r_p2_cnt <= w_p2_cnt_nxt;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_rsv    <= w_rsv;
      r_pass   <= w_pass;
      r_shf    <= w_shf;
      r_pri    <= w_pri;
      r_sec    <= w_sec;
    end
  end

  // POS/SIZE loads from WBUS, accepted only while no pass is in flight.
  always_ff @(posedge phase_h or negedge reset_l) begin
    if (!reset_l) begin
      r_pos  <= '0;
      r_size <= '0;
    end else if (!r_busy) begin
      if (sif.ld_pos_h) begin
        r_pos <= sif.wbus_h[POS_W-1:0];
      end
      if (sif.ld_size_h) begin
        r_size <= sif.wbus_h[SIZE_W-1:0];
      end
    end
  end

  assign sif.busy_h = r_busy;
  assign sif.done_h = r_done;
  assign sif.rsv_h  = r_rsv;
  assign sif.pass_h = r_pass;
  assign sif.shf_l  = r_shf;
  assign sif.pri_l  = r_pri;
  assign sif.sec_l  = r_sec;

endmodule

// File: tb/tb_dpm_shf_seq.sv
// tb_dpm_shf_seq: directed boundary cases plus randomized extract sequences,
// checked cycle by cycle against a pass-list model built from POS/SIZE.
`ifndef PRI_EXTZ_MM
`define PRI_EXTZ_MM 2'b00
`endif
`ifndef PRI_EXTZ_MR
`define PRI_EXTZ_MR 2'b01
`endif
`ifndef PRI_EXTZ_RR
`define PRI_EXTZ_RR 2'b10
`endif
`ifndef PRI_SECOND
`define PRI_SECOND 2'b11
`endif
`ifndef SEC_LITZERO
`define SEC_LITZERO 6'h20
`endif

module tb_dpm_shf_seq;
  logic phase_h = 1'b0;
  logic reset_l = 1'b0;
  int   n_chk   = 0;
  int   n_err   = 0;
  int   m_pos   = 0;
  int   m_size  = 0;

  dpm_shf_seq_if sif();

  dpm_shf_seq #(.POS_W(5), .SIZE_W(6)) dut (
    .phase_h (phase_h),
    .reset_l (reset_l),
    .sif     (sif)
  );

  always #5 phase_h = ~phase_h;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {busy, done, rsv, pass, shf_l, pri_l, sec_l}
  function automatic logic [16:0] vec(input bit busy, input bit done, input bit rsv,
                                      input bit pass, input logic [4:0] shf,
                                      input logic [1:0] pri, input logic [5:0] sec);
    return {busy, done, rsv, pass, shf, pri, sec};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {15'd0, sif.busy_h, sif.done_h, sif.rsv_h, sif.pass_h, sif.shf_l, sif.pri_l, sif.sec_l};
  endfunction

  function automatic logic [16:0] idle_vec();
    return vec(1'b0, 1'b0, 1'b0, 1'b0, 5'h1F, ~`PRI_EXTZ_MM, 6'h3F);
  endfunction

  // Runs one sequence: optional loads, start, then compares every cycle until idle.
  task automatic run_seq(input int pos, input int size, input bit ld_p, input bit ld_s,
                         input bit ld_at_start, input string tag);
    logic [16:0] q[$];
    logic [16:0] done_v;
    int e;
    int np;
    if (ld_p) begin
      sif.wbus_h = 8'($urandom_range(0, 7) * 32 + pos);
      sif.ld_pos_h = 1'b1;
      @(negedge phase_h);
      sif.ld_pos_h = 1'b0;
      m_pos = pos;
    end
    if (ld_s) begin
      sif.wbus_h = 8'($urandom_range(0, 3) * 64 + size);
      sif.ld_size_h = 1'b1;
      @(negedge phase_h);
      sif.ld_size_h = 1'b0;
      m_size = size;
    end
    // Expected pass list from the field rules
    done_v = vec(1'b0, 1'b1, 1'b0, 1'b0, 5'h1F, ~`PRI_EXTZ_MM, 6'h3F);
    e = m_pos + m_size;
    if (m_size > 32) begin
      q.push_back(vec(1'b0, 1'b1, 1'b1, 1'b0, 5'h1F, ~`PRI_EXTZ_MM, 6'h3F));
    end else if (e <= 32) begin
`ifdef SHF_SEQ_ZERO_SIZE_EN
      if (m_size == 0)
        q.push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 5'h1F, ~`PRI_SECOND, ~`SEC_LITZERO));
      else
        q.push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 5'(31 - m_pos), ~`PRI_EXTZ_MM, 6'(63 - m_size)));
`else
      q.push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 5'(31 - m_pos), ~`PRI_EXTZ_MM, 6'(63 - m_size)));
`endif
      q.push_back(done_v);
    end else begin
      q.push_back(vec(1'b1, 1'b0, 1'b0, 1'b0, 5'(31 - m_pos), ~`PRI_EXTZ_MR, 6'(63 - m_size)));
      q.push_back(vec(1'b1, 1'b0, 1'b0, 1'b1, 5'h1F, ~`PRI_EXTZ_RR, 6'(63 - (e - 32))));
      q.push_back(done_v);
    end
    sif.start_h = 1'b1;
    np = m_pos;
    if (ld_at_start) begin
      np = $urandom_range(0, 255);
      sif.wbus_h = 8'(np);
      sif.ld_pos_h = 1'b1;
      np = np % 32;
    end
    @(negedge phase_h);
    sif.start_h = 1'b0;
    sif.ld_pos_h = 1'b0;
    m_pos = np;
    foreach (q[i]) begin
      check_val($sformatf("%s_c%0d", tag, i + 1), obs_vec(), {15'd0, q[i]});
      // Loads while busy and starts outside IDLE must have no effect
      if (q[i][16] || q[i][15]) begin
        sif.start_h = 1'($urandom_range(0, 1));
        if (q[i][16]) begin
          sif.wbus_h = 8'($urandom_range(0, 255));
          sif.ld_pos_h = 1'($urandom_range(0, 1));
          sif.ld_size_h = 1'($urandom_range(0, 1));
        end
      end
      @(negedge phase_h);
      sif.start_h = 1'b0;
      sif.ld_pos_h = 1'b0;
      sif.ld_size_h = 1'b0;
    end
    check_val({tag, "_idle"}, obs_vec(), {15'd0, idle_vec()});
  endtask

  initial begin
    sif.wbus_h    = 8'h00;
    sif.ld_pos_h  = 1'b0;
    sif.ld_size_h = 1'b0;
    sif.start_h   = 1'b0;
    repeat (2) @(negedge phase_h);
    check_val("reset", obs_vec(), {15'd0, idle_vec()});
    reset_l = 1'b1;
    @(negedge phase_h);

    // Reset mid-P1 aborts at once
    run_seq(4, 8, 1'b1, 1'b1, 1'b0, "pre");
    sif.wbus_h = 8'd4; sif.ld_pos_h = 1'b1; @(negedge phase_h); sif.ld_pos_h = 1'b0;
    sif.wbus_h = 8'd8; sif.ld_size_h = 1'b1; @(negedge phase_h); sif.ld_size_h = 1'b0;
    sif.start_h = 1'b1; @(negedge phase_h); sif.start_h = 1'b0;
    check_val("rst_p1", obs_vec(),
              {15'd0, vec(1'b1, 1'b0, 1'b0, 1'b0, 5'd27, ~`PRI_EXTZ_MM, 6'h37)});
    #2 reset_l = 1'b0;
    #1 check_val("rst_async", obs_vec(), {15'd0, idle_vec()});
    @(negedge phase_h);
    reset_l = 1'b1;
    m_pos = 0;
    m_size = 0;
    repeat (3) begin
      @(negedge phase_h);
      check_val("rst_nodone", obs_vec(), {15'd0, idle_vec()});
    end
    // Registers cleared: start without loads sees POS=0, SIZE=0
    run_seq(0, 0, 1'b0, 1'b0, 1'b0, "rst_regs");

    // Directed cases
    run_seq(8, 16, 1'b1, 1'b1, 1'b0, "p8s16");
    run_seq(28, 8, 1'b1, 1'b1, 1'b0, "p28s8");
    run_seq(5, 33, 1'b1, 1'b1, 1'b0, "rsv33");
    run_seq(31, 1, 1'b1, 1'b1, 1'b0, "p31s1");
    run_seq(31, 2, 1'b1, 1'b1, 1'b0, "p31s2");
    run_seq(0, 32, 1'b1, 1'b1, 1'b0, "p0s32");
    run_seq(12, 0, 1'b1, 1'b1, 1'b0, "size0");
    run_seq(20, 20, 1'b1, 1'b1, 1'b1, "ldstart");
    run_seq(0, 0, 1'b0, 1'b0, 1'b0, "reuse");

    // Simultaneous POS and SIZE load from one WBUS value
    sif.wbus_h = 8'h0A; sif.ld_pos_h = 1'b1; sif.ld_size_h = 1'b1;
    @(negedge phase_h);
    sif.ld_pos_h = 1'b0; sif.ld_size_h = 1'b0;
    m_pos = 10; m_size = 10;
    run_seq(0, 0, 1'b0, 1'b0, 1'b0, "ldboth");

    // Randomized sequences
    for (int i = 0; i < 150; i++) begin
      run_seq($urandom_range(0, 31), $urandom_range(0, 40),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
